// File: rtl/mem_pkg.sv
// Shared constants, FSM state codes and requester-select codes for the
// instruction/data memory port arbiter.
package mem_pkg;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 10;
    localparam int REQ_AW  = 16;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_DONE   = 2'b10;

    localparam logic SEL_FETCH = 1'b0;
    localparam logic SEL_DATA  = 1'b1;

    typedef struct packed {
        logic sel;
        logic write;
        logic err;
    } access_t;

    // Any set bit above the memory address width means the word does not exist.
    function automatic logic addr_out_of_range(input logic [REQ_AW-1:0] addr);
        return addr[REQ_AW-1:ADDR_W] != '0;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle: fetch and load/store request/response signals.
interface mem_port_arbiter_if;
    import mem_pkg::*;

    logic              FetchReq;
    logic [REQ_AW-1:0] FetchAddr;
    logic              FetchAck;
    logic [DATA_W-1:0] FetchData;
    logic              FetchErr;

    logic              DataReq;
    logic              DataWrite;
    logic [REQ_AW-1:0] DataAddr;
    logic [DATA_W-1:0] DataWData;
    logic              DataAck;
    logic [DATA_W-1:0] DataRData;
    logic              DataErr;

    modport master (
        output FetchReq, FetchAddr, DataReq, DataWrite, DataAddr, DataWData,
        input  FetchAck, FetchData, FetchErr, DataAck, DataRData, DataErr
    );

    modport slave (
        input  FetchReq, FetchAddr, DataReq, DataWrite, DataAddr, DataWData,
        output FetchAck, FetchData, FetchErr, DataAck, DataRData, DataErr
    );

endinterface

// File: rtl/amemory16x1k.sv
// Single-port 16x1k memory with synchronous write and registered read
// (old data returned on read-during-write).
module amemory16x1k
    import mem_pkg::*;
(
    input  logic              CLK,
    input  logic [DATA_W-1:0] DataIn,
    input  logic [ADDR_W-1:0] Address,
    input  logic              Write,
    output logic [DATA_W-1:0] DataOut
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge CLK) begin
        if (Write) begin
            mem[Address] <= DataIn;
        end
        DataOut <= mem[Address];
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch vs load/store onto one memory port, with fetch starvation
// guard, address range check and a fixed 3-cycle IDLE/ACCESS/DONE sequence.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int MAX_FETCH_STALL = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    mem_port_arbiter_if.slave bus,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemDataIn,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] MemDataOut
);

    localparam int STALL_W = $clog2(MAX_FETCH_STALL + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(MAX_FETCH_STALL);

    logic [1:0]         state_q, state_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    access_t            acc_q, acc_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_din_q, mem_din_d;
    logic               mem_write_q, mem_write_d;
    logic               fetch_ack_q, fetch_ack_d;
    logic               fetch_err_q, fetch_err_d;
    logic [DATA_W-1:0]  fetch_data_q, fetch_data_d;
    logic               data_ack_q, data_ack_d;
    logic               data_err_q, data_err_d;
    logic [DATA_W-1:0]  data_rdata_q, data_rdata_d;

    logic               grant_data;
    logic [REQ_AW-1:0]  win_addr;
    logic [DATA_W-1:0]  rd_word;
    logic               done_fetch_rd;
    logic               done_data_rd;

    assign rd_word       = acc_q.err ? '0 : MemDataOut;
    assign done_fetch_rd = (state_q == ST_DONE) && (acc_q.sel == SEL_FETCH);
    assign done_data_rd  = (state_q == ST_DONE) && (acc_q.sel == SEL_DATA) && !acc_q.write;

    always_comb begin
        state_d      = state_q;
        stall_d      = stall_q;
        acc_d        = acc_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        mem_write_d  = 1'b0;
        fetch_ack_d  = 1'b0;
        fetch_err_d  = 1'b0;
        fetch_data_d = fetch_data_q;
        data_ack_d   = 1'b0;
        data_err_d   = 1'b0;
        data_rdata_d = data_rdata_q;
        grant_data   = bus.DataReq && (!bus.FetchReq || (stall_q != STALL_MAX));
        win_addr     = grant_data ? bus.DataAddr : bus.FetchAddr;

        case (state_q)
            ST_IDLE: begin
                if (bus.FetchReq && grant_data) begin
                    stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + STALL_W'(1);
                end else begin
                    stall_d = '0;
                end
                if (bus.FetchReq || bus.DataReq) begin
                    acc_d.sel   = grant_data ? SEL_DATA : SEL_FETCH;
                    acc_d.write = grant_data && bus.DataWrite;
                    acc_d.err   = addr_out_of_range(win_addr);
                    mem_addr_d  = win_addr[ADDR_W-1:0];
                    mem_din_d   = bus.DataWData;
                    mem_write_d = acc_d.write && !acc_d.err;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_DONE;
                if (acc_q.sel == SEL_FETCH) begin
                    fetch_ack_d = 1'b1;
                    fetch_err_d = acc_q.err;
                end else begin
                    data_ack_d = 1'b1;
                    data_err_d = acc_q.err;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (done_fetch_rd) begin
                    fetch_data_d = rd_word;
                end
                if (done_data_rd) begin
                    data_rdata_d = rd_word;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            stall_q      <= '0;
            acc_q        <= '0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_write_q  <= 1'b0;
            fetch_ack_q  <= 1'b0;
            fetch_err_q  <= 1'b0;
            fetch_data_q <= '0;
            data_ack_q   <= 1'b0;
            data_err_q   <= 1'b0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            stall_q      <= stall_d;
            acc_q        <= acc_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_write_q  <= mem_write_d;
            fetch_ack_q  <= fetch_ack_d;
            fetch_err_q  <= fetch_err_d;
            fetch_data_q <= fetch_data_d;
            data_ack_q   <= data_ack_d;
            data_err_q   <= data_err_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    // The memory samples Write on the same edge that samples Reset, so the
    // strobe is masked to keep a reset-aborted store from landing.
    assign MemWrite   = mem_write_q && !Reset;
    assign MemAddress = mem_addr_q;
    assign MemDataIn  = mem_din_q;

    // Memory data only arrives in the DONE cycle; bypass it so it is valid with Ack.
    assign bus.FetchAck  = fetch_ack_q;
    assign bus.FetchErr  = fetch_err_q;
    assign bus.FetchData = done_fetch_rd ? rd_word : fetch_data_q;
    assign bus.DataAck   = data_ack_q;
    assign bus.DataErr   = data_err_q;
    assign bus.DataRData = done_data_rd ? rd_word : data_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter driving the neighbouring 16x1k memory.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    logic              CLK = 1'b0;
    logic              Reset;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_write;
    logic [DATA_W-1:0] mem_data_out;

    int n_checks = 0;
    int n_fails  = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.MAX_FETCH_STALL(2)) u_dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .bus        (bus),
        .MemAddress (mem_address),
        .MemDataIn  (mem_data_in),
        .MemWrite   (mem_write),
        .MemDataOut (mem_data_out)
    );

    amemory16x1k u_mem (
        .CLK     (CLK),
        .DataIn  (mem_data_in),
        .Address (mem_address),
        .Write   (mem_write),
        .DataOut (mem_data_out)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request from IDLE; returns in the DONE (Ack) cycle with the
    // ACCESS-cycle memory pins and ack state captured.
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_we;
    logic              acc_any_ack;

    task automatic issue(input logic is_data, input logic wr,
                         input logic [15:0] addr, input logic [15:0] wd);
        if (is_data) begin
            bus.DataReq   = 1'b1;
            bus.DataWrite = wr;
            bus.DataAddr  = addr;
            bus.DataWData = wd;
        end else begin
            bus.FetchReq  = 1'b1;
            bus.FetchAddr = addr;
        end
        tick();
        acc_addr    = mem_address;
        acc_we      = mem_write;
        acc_any_ack = bus.FetchAck | bus.DataAck;
        tick();
    endtask

    task automatic release_req();
        bus.FetchReq = 1'b0;
        bus.DataReq  = 1'b0;
        tick();
    endtask

    task automatic store(input logic [15:0] addr, input logic [15:0] wd);
        issue(1'b1, 1'b1, addr, wd);
        $display("store addr=%h data=%h ack=%b err=%b", addr, wd, bus.DataAck, bus.DataErr);
        chk("store_ack", 16'(bus.DataAck), 16'd1);
        release_req();
    endtask

    task automatic load_chk(input string tag, input logic [15:0] addr,
                            input logic [15:0] exp_data, input logic exp_err);
        issue(1'b1, 1'b0, addr, 16'h0000);
        $display("load  addr=%h data=%h ack=%b err=%b", addr, bus.DataRData, bus.DataAck, bus.DataErr);
        chk({tag, "_ack"}, 16'(bus.DataAck), 16'd1);
        chk({tag, "_data"}, bus.DataRData, exp_data);
        chk({tag, "_err"}, 16'(bus.DataErr), 16'(exp_err));
        release_req();
    endtask

    logic [5:0] exp_order;
    logic       exp_is_data;

    initial begin
        Reset         = 1'b1;
        bus.FetchReq  = 1'b0;
        bus.FetchAddr = 16'h0000;
        bus.DataReq   = 1'b0;
        bus.DataWrite = 1'b0;
        bus.DataAddr  = 16'h0000;
        bus.DataWData = 16'h0000;
        tick();
        tick();
        Reset = 1'b0;

        // Reset state
        chk("rst_mem_addr",   16'(mem_address), 16'h0000);
        chk("rst_mem_din",    mem_data_in, 16'h0000);
        chk("rst_mem_write",  16'(mem_write), 16'h0000);
        chk("rst_fetch_ack",  16'(bus.FetchAck), 16'h0000);
        chk("rst_data_ack",   16'(bus.DataAck), 16'h0000);
        chk("rst_fetch_data", bus.FetchData, 16'h0000);
        chk("rst_data_rdata", bus.DataRData, 16'h0000);
        chk("rst_fetch_err",  16'(bus.FetchErr), 16'h0000);
        chk("rst_data_err",   16'(bus.DataErr), 16'h0000);

        // Preload memory contents used later
        store(16'h0200, 16'hBEEF);
        store(16'h0000, 16'h1111);
        store(16'h0001, 16'h2222);
        store(16'h0010, 16'h5A5A);

        // Single fetch: address in ACCESS, Ack and data in DONE
        issue(1'b0, 1'b0, 16'h0200, 16'h0000);
        $display("fetch addr=0200 data=%h ack=%b err=%b", bus.FetchData, bus.FetchAck, bus.FetchErr);
        chk("fetch_mem_addr",   16'(acc_addr), 16'h0200);
        chk("fetch_early_ack",  16'(acc_any_ack), 16'h0000);
        chk("fetch_ack",        16'(bus.FetchAck), 16'd1);
        chk("fetch_data",       bus.FetchData, 16'hBEEF);
        chk("fetch_err",        16'(bus.FetchErr), 16'd0);
        chk("fetch_data_noack", 16'(bus.DataAck), 16'd0);
        release_req();

        // Store then load back
        issue(1'b1, 1'b1, 16'h0005, 16'h1234);
        $display("store addr=0005 data=1234 ack=%b we_access=%b we_done=%b", bus.DataAck, acc_we, mem_write);
        chk("st_we_access",  16'(acc_we), 16'd1);
        chk("st_din",        mem_data_in, 16'h1234);
        chk("st_we_done",    16'(mem_write), 16'd0);
        chk("st_ack",        16'(bus.DataAck), 16'd1);
        chk("st_err",        16'(bus.DataErr), 16'd0);
        release_req();
        chk("st_we_idle",    16'(mem_write), 16'd0);
        load_chk("ld5", 16'h0005, 16'h1234, 1'b0);
        chk("ld5_hold",      bus.DataRData, 16'h1234);
        chk("fetch_hold",    bus.FetchData, 16'hBEEF);

        // Out-of-range store is suppressed; out-of-range load reads zero
        issue(1'b1, 1'b1, 16'h0400, 16'h7777);
        $display("store addr=0400 data=7777 ack=%b err=%b we_access=%b", bus.DataAck, bus.DataErr, acc_we);
        chk("oor_st_we",  16'(acc_we), 16'd0);
        chk("oor_st_ack", 16'(bus.DataAck), 16'd1);
        chk("oor_st_err", 16'(bus.DataErr), 16'd1);
        chk("oor_st_rd_hold", bus.DataRData, 16'h1234);
        release_req();
        load_chk("ld0_after_oor", 16'h0000, 16'h1111, 1'b0);
        load_chk("ld_ffff", 16'hFFFF, 16'h0000, 1'b1);

        // Reset in the ACCESS cycle of a store drops it
        bus.DataReq   = 1'b1;
        bus.DataWrite = 1'b1;
        bus.DataAddr  = 16'h0010;
        bus.DataWData = 16'hDEAD;
        tick();
        chk("rs_we_access", 16'(mem_write), 16'd1);
        Reset = 1'b1;
        tick();
        $display("reset-abort store addr=0010 we=%b ack=%b", mem_write, bus.DataAck);
        chk("rs_we_after", 16'(mem_write), 16'd0);
        chk("rs_no_ack",   16'(bus.DataAck), 16'd0);
        Reset       = 1'b0;
        bus.DataReq = 1'b0;
        tick();
        chk("rs_no_ack2",  16'(bus.DataAck), 16'd0);
        load_chk("rs_unchanged", 16'h0010, 16'h5A5A, 1'b0);

        // Back-to-back fetches: Acks 3 cycles apart, data held between
        issue(1'b0, 1'b0, 16'h0000, 16'h0000);
        $display("fetch addr=0000 data=%h ack=%b", bus.FetchData, bus.FetchAck);
        chk("bb1_ack",  16'(bus.FetchAck), 16'd1);
        chk("bb1_data", bus.FetchData, 16'h1111);
        tick();
        bus.FetchAddr = 16'h0001;
        chk("bb_idle_ack",  16'(bus.FetchAck), 16'd0);
        chk("bb_idle_data", bus.FetchData, 16'h1111);
        tick();
        chk("bb_acc_ack",   16'(bus.FetchAck), 16'd0);
        chk("bb_acc_data",  bus.FetchData, 16'h1111);
        tick();
        $display("fetch addr=0001 data=%h ack=%b", bus.FetchData, bus.FetchAck);
        chk("bb2_ack",  16'(bus.FetchAck), 16'd1);
        chk("bb2_data", bus.FetchData, 16'h2222);
        release_req();

        // Contention: both held, expect D,D,F,D,D,F (bit i = 1 for Data)
        exp_order     = 6'b011011;
        bus.FetchReq  = 1'b1;
        bus.FetchAddr = 16'h0000;
        bus.DataReq   = 1'b1;
        bus.DataWrite = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.DataAddr = 16'(i);
            exp_is_data  = exp_order[i];
            tick();
            chk("arb_acc_noack", 16'(bus.FetchAck | bus.DataAck), 16'd0);
            tick();
            $display("grant %0d fetch_ack=%b data_ack=%b", i, bus.FetchAck, bus.DataAck);
            chk("arb_data_ack",  16'(bus.DataAck), 16'(exp_is_data));
            chk("arb_fetch_ack", 16'(bus.FetchAck), 16'(!exp_is_data));
            tick();
        end
        bus.FetchReq = 1'b0;
        bus.DataReq  = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
